// File: rtl/tetris_pkg.sv
// Shared types and constants for the piece sequencer and its LFSR.
package tetris_pkg;

    localparam int          NUM_PIECES = 5;
    localparam logic [15:0] LFSR_MASK  = 16'hB400;

    typedef logic [2:0] piece_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } seq_state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, right-shifting, always enabled.
// A zero seed would lock up the register, so it is replaced by 16'h0001.
module lfsr16
    import tetris_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] state_o
);

    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Galois step: shift right, fold the mask in when a one falls out.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= INIT;
        else       lfsr_q <= lfsr_d;
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/piece_sequencer.sv
// Tetris piece sequencer: preview queue refilled from an LFSR, handed out
// over a next_req/next_valid handshake.
// Optional bag randomizer: define PIECE_SEQ_BAG_RANDOMIZER_EN.
//
//   state | meaning
//   ------+---------------------------------------------
//   IDLE  | after reset, waiting for start
//   FILL  | queue flushed, refilling up to QUEUE_DEPTH
//   READY | serving requests, refilling as entries drain
module piece_sequencer
    import tetris_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        next_req,
    output logic        next_valid,
    output logic [2:0]  cur_piece,
    output logic [2:0]  preview_piece,
    output logic [15:0] piece_count
);

    localparam logic [2:0] DEPTH = 3'(QUEUE_DEPTH);

    seq_state_t  state_q, state_d;
    piece_t      queue_q [QUEUE_DEPTH];
    piece_t      queue_d [QUEUE_DEPTH];
    logic [2:0]  occ_q, occ_d;
    piece_t      cur_q, cur_d;
    logic [15:0] cnt_q, cnt_d;

    logic [15:0] lfsr;
    piece_t      cand;
    logic        accept;
    logic        push;
    logic        pop;
    logic        unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i   (clk),
        .rst_i   (rst),
        .state_o (lfsr)
    );

    assign cand        = lfsr[2:0];
    assign unused_lfsr = ^lfsr[15:3];

`ifdef PIECE_SEQ_BAG_RANDOMIZER_EN
    logic [4:0] bag_q, bag_d;
    logic [4:0] cand_bit;
    logic [4:0] bag_set;

    // Candidate must be a legal piece not yet drawn from the current bag.
    always_comb begin
        cand_bit = 5'b00001 << cand;
        accept   = (cand < 3'(NUM_PIECES)) && ((bag_q & cand_bit) == 5'b00000);
    end

    // Mark pushed pieces; a full bag empties on the same edge.
    always_comb begin
        bag_set = bag_q | cand_bit;
        bag_d   = bag_q;
        if (start)     bag_d = 5'b00000;
        else if (push) bag_d = (bag_set == 5'b11111) ? 5'b00000 : bag_set;
    end

    // Bag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bag_q <= 5'b00000;
        else     bag_q <= bag_d;
    end
`else
    // Plain rejection sampling of the low three LFSR bits.
    always_comb begin
        accept = (cand < 3'(NUM_PIECES));
    end
`endif

    // Handshake and refill qualifiers; start suppresses both.
    always_comb begin
        pop  = (state_q == READY) && next_req && (occ_q != 3'd0) && !start;
        push = !start && (state_q != IDLE) && accept && ((occ_q < DEPTH) || pop);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; start restarts the fill from any state.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = FILL;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                FILL:    if (occ_q == DEPTH) state_d = READY;
                READY:   state_d = READY;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs, independent of next_req.
    always_comb begin
        next_valid    = (state_q == READY) && (occ_q != 3'd0);
        preview_piece = (occ_q != 3'd0) ? queue_q[0] : 3'd0;
    end

    // Queue, current piece and counter next state. Pop shifts first, so a
    // simultaneous push lands one slot lower than the old tail.
    always_comb begin
        queue_d = queue_q;
        occ_d   = occ_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        if (start) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) queue_d[i] = '0;
            occ_d = 3'd0;
            cnt_d = 16'h0000;
        end else begin
            if (pop) begin
                for (int i = 0; i < QUEUE_DEPTH - 1; i++) queue_d[i] = queue_q[i + 1];
                queue_d[QUEUE_DEPTH - 1] = '0;
                cur_d = queue_q[0];
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'h0001;
            end
            if (push) queue_d[occ_q - 3'(pop)] = cand;
            occ_d = occ_q + 3'(push) - 3'(pop);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) queue_q[i] <= '0;
            occ_q <= 3'd0;
            cur_q <= '0;
            cnt_q <= 16'h0000;
        end else begin
            queue_q <= queue_d;
            occ_q   <= occ_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cur_piece   = cur_q;
    assign piece_count = cnt_q;

endmodule

// File: tb/tb_piece_sequencer.sv
// Self-checking bench for piece_sequencer: directed phases plus a cycle
// model of the LFSR, queue and counters built from the behavioural rules.
module tb_piece_sequencer;

    localparam int          D    = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        next_req;
    logic        next_valid;
    logic [2:0]  cur_piece;
    logic [2:0]  preview_piece;
    logic [15:0] piece_count;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_lfsr;
    int          m_state;
    int          m_q[$];
    int          m_cur;
    int          m_cnt;
    logic [4:0]  m_bag;

    always #5 clk = ~clk;

    piece_sequencer #(.QUEUE_DEPTH(D), .LFSR_SEED(SEED)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .next_req      (next_req),
        .next_valid    (next_valid),
        .cur_piece     (cur_piece),
        .preview_piece (preview_piece),
        .piece_count   (piece_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic model_reset();
        m_lfsr  = SEED;
        m_state = 0;
        m_q.delete();
        m_cur   = 0;
        m_cnt   = 0;
        m_bag   = 5'b0;
    endtask

    // One clock of the reference behaviour, using pre-edge model state.
    task automatic model_step(input logic s, input logic r);
        int  cand;
        bit  acc, pop, push;
        int  size;
        cand = int'(m_lfsr[2:0]);
        size = m_q.size();
        pop  = (m_state == 2) && r && (size != 0) && !s;
        acc  = (cand < 5);
`ifdef PIECE_SEQ_BAG_RANDOMIZER_EN
        if (acc && m_bag[cand]) acc = 1'b0;
`endif
        push = !s && (m_state != 0) && acc && ((size < D) || pop);
        if (s) begin
            m_state = 1;
            m_q.delete();
            m_cnt = 0;
            m_bag = 5'b0;
        end else begin
            if (m_state == 1 && size == D) m_state = 2;
            if (pop) begin
                m_cur = m_q.pop_front();
                if (m_cnt < 65535) m_cnt++;
            end
            if (push) begin
                m_q.push_back(cand);
`ifdef PIECE_SEQ_BAG_RANDOMIZER_EN
                m_bag[cand] = 1'b1;
                if (m_bag == 5'b11111) m_bag = 5'b0;
`endif
            end
        end
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"},   32'(next_valid),    32'((m_state == 2) && (m_q.size() != 0)));
        chk({tag, ".preview"}, 32'(preview_piece), (m_q.size() != 0) ? m_q[0] : 0);
        chk({tag, ".cur"},     32'(cur_piece),     m_cur);
        chk({tag, ".count"},   32'(piece_count),   m_cnt);
    endtask

    task automatic tick(input string tag, input logic s, input logic r);
        start    = s;
        next_req = r;
        model_step(s, r);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic wait_fill(input string tag);
        int n;
        n = 0;
        while (!next_valid && n < 64) begin
            tick(tag, 1'b0, 1'b0);
            n++;
        end
        chk({tag, ".in_budget"}, 32'(n < 64), 32'd1);
        chk({tag, ".occ"}, m_q.size(), D);
        chk({tag, ".prev_range"}, 32'(preview_piece < 3'd5), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] pv;
        logic       hs;
        int         hs_cnt;
        int         pops;
        int         cyc;
        logic [2:0] saved_cur;
        int         hist[5];
        logic [4:0] grp;

        rst      = 1'b1;
        start    = 1'b0;
        next_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid",   32'(next_valid),    32'd0);
        chk("rst.cur",     32'(cur_piece),     32'd0);
        chk("rst.count",   32'(piece_count),   32'd0);
        chk("rst.preview", 32'(preview_piece), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) tick("idle", 1'b0, 1'b1);
        chk("idle.valid_end", 32'(next_valid), 32'd0);

        tick("fill.start", 1'b1, 1'b0);
        wait_fill("fill");

        hs_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            pv = preview_piece;
            hs = next_valid;
            tick("drain", 1'b0, 1'b1);
            if (hs) begin
                hs_cnt++;
                chk("drain.cur_eq_prev", 32'(cur_piece), 32'(pv));
            end
            chk("drain.cur_range", 32'(cur_piece < 3'd5), 32'd1);
        end
        chk("drain.count", 32'(piece_count), hs_cnt);

        tick("restart.start0", 1'b1, 1'b0);
        wait_fill("restart.fill");
        pops = 0;
        cyc  = 0;
        while (pops < 7 && cyc < 100) begin
            hs = next_valid;
            tick("restart.pop", 1'b0, 1'b1);
            if (hs) pops++;
            cyc++;
        end
        chk("restart.pops", pops, 7);
        chk("restart.count7", 32'(piece_count), 32'd7);
        saved_cur = cur_piece;
        tick("restart.start", 1'b1, 1'b1);
        chk("restart.count0", 32'(piece_count), 32'd0);
        chk("restart.valid0", 32'(next_valid), 32'd0);
        chk("restart.cur_hold", 32'(cur_piece), 32'(saved_cur));
        wait_fill("restart.refill");

        tick("dist.start", 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) hist[k] = 0;
        grp  = 5'b0;
        pops = 0;
        cyc  = 0;
`ifdef PIECE_SEQ_BAG_RANDOMIZER_EN
        while (pops < 500 && cyc < 4000) begin
`else
        while (pops < 5000 && cyc < 20000) begin
`endif
            hs = next_valid;
            tick("dist", 1'b0, 1'b1);
            cyc++;
            if (hs) begin
                pops++;
                if (cur_piece < 3'd5) begin
                    hist[cur_piece]++;
                    grp[cur_piece] = 1'b1;
                end
                if (pops % 5 == 0) begin
`ifdef PIECE_SEQ_BAG_RANDOMIZER_EN
                    chk("bag.group_perm", 32'(grp), 32'h1F);
`endif
                    grp = 5'b0;
                end
            end
        end
`ifdef PIECE_SEQ_BAG_RANDOMIZER_EN
        chk("bag.pops", pops, 500);
        for (int k = 0; k < 5; k++) chk("bag.hist", hist[k], 100);
`else
        chk("hist.pops", pops, 5000);
        for (int k = 0; k < 5; k++)
            chk("hist.range", 32'(hist[k] >= 800 && hist[k] <= 1200), 32'd1);
`endif

        for (int i = 0; i < 4; i++) tick("async.pre", 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async.valid",   32'(next_valid),    32'd0);
        chk("async.cur",     32'(cur_piece),     32'd0);
        chk("async.count",   32'(piece_count),   32'd0);
        chk("async.preview", 32'(preview_piece), 32'd0);
        model_reset();
        #1;
        rst = 1'b0;
        tick("async.post_idle", 1'b0, 1'b1);
        tick("async.start", 1'b1, 1'b0);
        wait_fill("async.fill");
        for (int i = 0; i < 10; i++) tick("async.drain", 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piece_sequencer.md
# piece_sequencer

Generates the stream of upcoming Tetris piece indices (0–4) for the game controller. It keeps a small preview queue that refills itself from a free-running LFSR, and hands pieces out over a request/valid handshake. Its `cur_piece` output drives the piece-to-4x4-matrix decoder directly. It sits between the game FSM and that decoder.

## Interface
- `QUEUE_DEPTH`, 3: number of queued upcoming pieces, legal range 2–7.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins a new game (flush and refill).
- `next_req` input 1: game FSM requests the next piece.
- `next_valid` output 1: a piece is available; a transfer occurs when `next_req && next_valid`.
- `cur_piece` output 3: most recently dispensed piece index, fed to the matrix decoder.
- `preview_piece` output 3: queue head, i.e. the piece the next transfer will deliver.
- `piece_count` output 16: pieces dispensed since the last `start`; saturates at 16'hFFFF.

## Operation
- States:
  - IDLE: after reset; `start` goes to FILL.
  - FILL: refilling; goes to READY when occupancy equals QUEUE_DEPTH.
  - READY: serves requests; `start` from any state goes to FILL.
- LFSR:
  - 16-bit Galois, mask 16'hB400, shifts right.
  - Advances every cycle in every state, including IDLE.
  - `start` does not reseed it.
- Candidate is `lfsr[2:0]`. It is rejected if ≥5; otherwise it is accepted.
- Push: an accepted candidate is written at the tail when occupancy < QUEUE_DEPTH, or when a pop occurs in the same cycle.
- Pop:
  - Occurs in READY when `next_req && next_valid`.
  - `cur_piece` <= head, the queue shifts toward the head, and `piece_count` increments.
  - Simultaneous push and pop keeps occupancy unchanged.
- `next_valid` = (state==READY) && occupancy≠0.
  - Occupancy can drain below QUEUE_DEPTH in READY; the state stays READY and refilling continues.
- `preview_piece` = entry 0 of the queue, or 0 when the queue is empty.
- `start`:
  - Empties the queue and clears `piece_count`.
  - Clears the bag mask when BAG_RANDOMIZER_EN is defined.
  - Holds `cur_piece`.
  - Any `next_req` in the same cycle is ignored.
  - No push occurs that cycle.
- `next_req` outside READY is ignored. No error is raised.

## Timing
- Reset values: state IDLE, `lfsr`=LFSR_SEED, all queue entries 0, occupancy 0, `cur_piece`=0, `preview_piece`=0, `next_valid`=0, `piece_count`=0.
- `cur_piece`, `piece_count` and the queue update on the clock edge that completes a transfer.
  - `cur_piece` is therefore visible one cycle after the handshake cycle.
- `next_valid` and `preview_piece` are combinational from registered state and occupancy. They do not depend on `next_req`.
- At most one push and one pop per cycle.
- Fill time after `start` is at least QUEUE_DEPTH cycles and is unbounded only by rejection streaks.
- Back-to-back pops every cycle are legal. `next_valid` drops if occupancy reaches 0.
- `rst` asserted mid-operation returns every register to its reset value immediately (asynchronous).

## Configuration
- `PIECE_SEQ_BAG_RANDOMIZER_EN` defined:
  - A 5-bit bag mask additionally rejects any candidate whose bit is already set; accepted candidates set their bit.
  - When the accept sets the fifth bit, the mask clears on that same edge.
  - Result: every aligned group of 5 pieces after `start` is a permutation of 0–4.
- Undefined: no mask; pieces are independent, uniform over 0–4.

## Structure
- Shared package `tetris_pkg`:
  - `NUM_PIECES`=5.
  - `piece_t` (logic [2:0]).
  - `seq_state_t` enum {IDLE, FILL, READY}.
  - `LFSR_MASK`=16'hB400.
- One sub-module: `lfsr16` (seed parameter, always-enable shift, 16-bit state out). Queue, bag and FSM stay in `piece_sequencer`.

## Test plan
- Reset check: assert `rst` for 3 cycles → `next_valid`=0, `cur_piece`=0, `piece_count`=0; with no `start` for 100 cycles, `next_valid` stays 0.
- Fill: `start` pulse, `next_req`=0 → `next_valid` rises within 64 cycles and the occupancy model reads 3; `preview_piece` is always ≤4.
- Burst drain: hold `next_req`=1 for 200 cycles → each `cur_piece` equals the previous `preview_piece`; `piece_count`=number of handshakes; no value is ≥5.
- Restart mid-game: after 7 pops, pulse `start` together with `next_req` → `piece_count`=0, `next_valid`=0 the next cycle, `cur_piece` unchanged.
- Bag mode (macro defined): 500 pops → every consecutive group of 5 pops is a permutation of {0,1,2,3,4}. Undefined: a histogram over 5000 pops shows each value in the range 800–1200.
- Async reset mid-drain: assert `rst` between clock edges → all outputs return to reset values before the next edge.
